// File: rtl/console_pkg.sv
// console_pkg: shared types and constants for the console UART receiver.
// Holds the receive FSM states, register offsets and STATUS bit positions.
package console_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

    localparam logic [31:0] CONSOLE_DATA_OFS   = 32'd0;
    localparam logic [31:0] CONSOLE_STATUS_OFS = 32'd4;

    localparam int ST_NEMPTY  = 0;
    localparam int ST_OVR     = 1;
    localparam int ST_FERR    = 2;
    localparam int ST_CNT_LSB = 8;

endpackage

// File: rtl/wb4_if.sv
// wb4_if: Wishbone B4 classic bus bundle for the peripheral bus.
// DAT_O carries master write data, DAT_I carries slave read data.
interface wb4_if;

    logic        clk;
    logic        rst;
    logic        CYC;
    logic        STB;
    logic        WE;
    logic [31:0] ADR;
    logic [31:0] DAT_O;
    logic [31:0] DAT_I;
    logic        ACK;

    modport slave (
        input  clk, rst, CYC, STB, WE, ADR, DAT_O,
        output DAT_I, ACK
    );

    modport master (
        output clk, rst, CYC, STB, WE, ADR, DAT_O,
        input  DAT_I, ACK
    );

endinterface

// File: rtl/console_rx_fifo.sv
// console_rx_fifo: DEPTH-entry circular byte FIFO for received characters.
// A pop is applied before a push, so a full FIFO accepts push+pop together.
module console_rx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [7:0]                 i_din,
    output logic [7:0]                 o_dout,
    output logic                       o_empty,
    output logic                       o_full,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          w_do_pop;
    logic          w_do_push;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_count   = r_count;
    assign o_dout    = r_mem[r_rptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // storage array, written on an accepted push
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr] <= i_din;
    end

    // pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
            else if (w_do_pop && !w_do_push) r_count <= r_count - 1'b1;
        end
    end

endmodule

// File: rtl/console_rx.sv
// console_rx: Wishbone-readable 8N1 UART receiver for the console path.
// CONSOLE_RX_FIFO_EN selects a DEPTH-entry FIFO instead of one holding register.
module console_rx
    import console_pkg::*;
#(
    parameter int FREQUENCY    = 25000000,
    parameter int BAUD_RATE    = 115200,
    parameter int DELAY_CLOCKS = FREQUENCY / BAUD_RATE,
    parameter int DEPTH        = 8
) (
    input  logic clk,
    input  logic rst,
    wb4_if.slave wb,
    input  logic rx,
    output logic rx_irq
);

    localparam logic [31:0] C_FULL = 32'(DELAY_CLOCKS - 1);
    localparam logic [31:0] C_HALF = 32'(DELAY_CLOCKS / 2 - 1);

    rx_state_e   r_state, w_state_nxt;
    logic [31:0] r_cnt, w_cnt_nxt;
    logic [2:0]  r_nbit, w_nbit_nxt;
    logic [7:0]  r_shift, w_shift_nxt;
    logic        r_armed, w_armed_nxt;
    logic [1:0]  r_sync;
    logic        r_ovr, r_ferr, r_ack;
    logic [31:0] r_dat;
    logic        w_rxs, w_push, w_ferr_set, w_ovr_set;
    logic        w_req, w_sel_st, w_pop, w_clr_ovr, w_clr_ferr;
    logic        w_empty;
    logic [7:0]  w_head, w_count8;
    logic [31:0] w_rdata;

    assign w_rxs = r_sync[1];

    // two-flop synchronizer on the serial line, idles high
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_sync <= 2'b11;
        else      r_sync <= {r_sync[0], rx};
    end

    // receive FSM state and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_nbit  <= '0;
            r_shift <= '0;
            r_armed <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_nbit  <= w_nbit_nxt;
            r_shift <= w_shift_nxt;
            r_armed <= w_armed_nxt;
        end
    end

    // next state: arming only in IDLE keeps a held-low break to one error
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 32'd1;
        w_nbit_nxt  = r_nbit;
        w_shift_nxt = r_shift;
        w_armed_nxt = r_armed;
        w_push      = 1'b0;
        w_ferr_set  = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_cnt_nxt  = '0;
                w_nbit_nxt = '0;
                if (w_rxs) begin
                    w_armed_nxt = 1'b1;
                end else if (r_armed) begin
                    w_armed_nxt = 1'b0;
                    w_state_nxt = START;
                end
            end
            START: begin
                if (r_cnt == C_HALF) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = w_rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (r_cnt == C_FULL) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {w_rxs, r_shift[7:1]};
                    w_nbit_nxt  = r_nbit + 3'd1;
                    if (r_nbit == 3'd7) w_state_nxt = STOP;
                end
            end
            STOP: begin
                if (r_cnt == C_FULL) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                    w_push      = w_rxs;
                    w_ferr_set  = !w_rxs;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign w_req      = wb.CYC && wb.STB && !r_ack;
    assign w_sel_st   = wb.ADR[2] == CONSOLE_STATUS_OFS[2];
    assign w_pop      = w_req && !wb.WE && !w_sel_st && !w_empty;
    assign w_clr_ovr  = w_req && wb.WE && w_sel_st && wb.DAT_O[ST_OVR];
    assign w_clr_ferr = w_req && wb.WE && w_sel_st && wb.DAT_O[ST_FERR];

`ifdef CONSOLE_RX_FIFO_EN
    logic [$clog2(DEPTH+1)-1:0] w_fcount;
    logic                       w_full;

    console_rx_fifo #(
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (r_shift),
        .o_dout  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_count (w_fcount)
    );

    assign w_count8  = 8'(w_fcount);
    assign w_ovr_set = w_push && w_full && !w_pop;
`else
    logic [7:0] r_hold;
    logic       r_valid;

    // single holding register; a same-cycle pop frees it for the push
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hold  <= '0;
            r_valid <= 1'b0;
        end else begin
            if (w_pop) r_valid <= 1'b0;
            if (w_push && (!r_valid || w_pop)) begin
                r_hold  <= r_shift;
                r_valid <= 1'b1;
            end
        end
    end

    assign w_empty   = !r_valid;
    assign w_head    = r_hold;
    assign w_count8  = {7'd0, r_valid};
    assign w_ovr_set = w_push && r_valid && !w_pop;
`endif

    assign rx_irq = !w_empty;

    // read mux for the addressed register
    always_comb begin
        w_rdata = '0;
        if (w_sel_st) begin
            w_rdata[ST_NEMPTY]         = !w_empty;
            w_rdata[ST_OVR]            = r_ovr;
            w_rdata[ST_FERR]           = r_ferr;
            w_rdata[ST_CNT_LSB +: 8]   = w_count8;
        end else if (!w_empty) begin
            w_rdata[7:0] = w_head;
        end
    end

    // bus ack, read data and sticky flags; a set beats a clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ack  <= 1'b0;
            r_dat  <= '0;
            r_ovr  <= 1'b0;
            r_ferr <= 1'b0;
        end else begin
            r_ack <= w_req;
            r_dat <= (w_req && !wb.WE) ? w_rdata : '0;
            if (w_ovr_set)       r_ovr <= 1'b1;
            else if (w_clr_ovr)  r_ovr <= 1'b0;
            if (w_ferr_set)      r_ferr <= 1'b1;
            else if (w_clr_ferr) r_ferr <= 1'b0;
        end
    end

    assign wb.ACK   = r_ack;
    assign wb.DAT_I = r_dat;

endmodule

// File: tb/tb_console_rx.sv
// tb_console_rx: directed bench for the console UART receiver.
// Expectations follow CONSOLE_RX_FIFO_EN when it is defined for the build.
module tb_console_rx;

    localparam int DC = 10;

    typedef struct {
        logic [7:0]  b;
        logic [31:0] st;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx = 1'b1;
    logic        rx_irq;
    logic [31:0] rd;
    int          vectors = 0;
    int          miscompares = 0;
    vec_t        v[6];

    wb4_if wbb();

    assign wbb.clk = clk;
    assign wbb.rst = rst_n;

    always #5 clk = ~clk;

    console_rx #(
        .FREQUENCY (1000000),
        .BAUD_RATE (100000),
        .DEPTH     (8)
    ) dut (
        .clk    (clk),
        .rst    (rst_n),
        .wb     (wbb),
        .rx     (rx),
        .rx_irq (rx_irq)
    );

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h want %08h", nm, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stopb);
        rx = 1'b0;
        tick(DC);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(DC);
        end
        rx = stopb;
        tick(DC);
        if (stopb) rx = 1'b1;
    endtask

    task automatic wb_cyc(input logic we, input logic [31:0] adr,
                          input logic [31:0] wd, output logic [31:0] q);
        logic got;
        got = 1'b0;
        wbb.CYC = 1'b1;
        wbb.STB = 1'b1;
        wbb.WE = we;
        wbb.ADR = adr;
        wbb.DAT_O = wd;
        for (int i = 0; i < 4 && !got; i++) begin
            @(posedge clk);
            #1;
            if (wbb.ACK) got = 1'b1;
        end
        q = wbb.DAT_I;
        wbb.CYC = 1'b0;
        wbb.STB = 1'b0;
        wbb.WE = 1'b0;
        if (!got) begin
            vectors++;
            miscompares++;
            $display("FAIL ack_timeout: got no ACK want ACK adr %08h", adr);
        end
        @(posedge clk);
        #1;
        check("ack_one_cycle", {31'd0, wbb.ACK}, 32'd0);
    endtask

    task automatic rd_chk(input string nm, input logic [31:0] adr,
                          input logic [31:0] exp);
        logic [31:0] q;
        wb_cyc(1'b0, adr, 32'd0, q);
        check(nm, q, exp);
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] d);
        logic [31:0] q;
        wb_cyc(1'b1, adr, d, q);
    endtask

    initial begin
        v[0] = '{8'h55, 32'h101};
        v[1] = '{8'h00, 32'h101};
        v[2] = '{8'hFF, 32'h101};
        v[3] = '{8'hA3, 32'h101};
        v[4] = '{8'h81, 32'h101};
        v[5] = '{8'h3C, 32'h101};

        wbb.CYC = 1'b0;
        wbb.STB = 1'b0;
        wbb.WE = 1'b0;
        wbb.ADR = '0;
        wbb.DAT_O = '0;

        tick(3);
        check("rst_irq", {31'd0, rx_irq}, 32'd0);
        check("rst_ack", {31'd0, wbb.ACK}, 32'd0);
        check("rst_dat", wbb.DAT_I, 32'd0);
        rst_n = 1'b1;
        tick(5);
        rd_chk("rst_status", 32'd4, 32'd0);
        rd_chk("empty_data", 32'd0, 32'd0);

        for (int k = 0; k < 6; k++) begin
            send_frame(v[k].b, 1'b1);
            tick(5);
            check("irq_set", {31'd0, rx_irq}, 32'd1);
            rd_chk("vec_status", 32'd4, v[k].st);
            rd_chk("vec_data", 32'd0, {24'd0, v[k].b});
            rd_chk("vec_status_after", 32'd4, 32'd0);
        end

        // irq drops on the ACK edge of the DATA read
        send_frame(8'h55, 1'b1);
        tick(5);
        wb_cyc(1'b0, 32'd0, 32'd0, rd);
        check("irq_fall", {31'd0, rx_irq}, 32'd0);
        check("irq_fall_data", rd, 32'h55);

        // DATA write is ignored
        send_frame(8'h66, 1'b1);
        tick(5);
        wr(32'd0, 32'hFF);
        rd_chk("dwr_status", 32'd4, 32'h101);
        rd_chk("dwr_data", 32'd0, 32'h66);

        // three back-to-back bytes
        send_frame(8'h41, 1'b1);
        send_frame(8'h42, 1'b1);
        send_frame(8'h43, 1'b1);
        tick(5);
`ifdef CONSOLE_RX_FIFO_EN
        rd_chk("b2b_status", 32'd4, 32'h301);
        rd_chk("b2b_d0", 32'd0, 32'h41);
        rd_chk("b2b_d1", 32'd0, 32'h42);
        rd_chk("b2b_d2", 32'd0, 32'h43);
`else
        rd_chk("b2b_status", 32'd4, 32'h103);
        rd_chk("b2b_d0", 32'd0, 32'h41);
        rd_chk("b2b_ovr", 32'd4, 32'h2);
        wr(32'd4, 32'h2);
`endif
        rd_chk("b2b_end", 32'd4, 32'd0);

        // overflow with nine bytes
        for (int i = 0; i < 9; i++) send_frame(8'(i), 1'b1);
        tick(5);
`ifdef CONSOLE_RX_FIFO_EN
        rd_chk("ovr_status", 32'd4, 32'h803);
        for (int i = 0; i < 8; i++) rd_chk("ovr_data", 32'd0, 32'(i));
`else
        rd_chk("ovr_status", 32'd4, 32'h103);
        rd_chk("ovr_data", 32'd0, 32'h00);
`endif
        rd_chk("ovr_lost", 32'd4, 32'h2);
        rd_chk("ovr_empty_rd", 32'd0, 32'd0);
        wr(32'd4, 32'h2);
        rd_chk("ovr_clr", 32'd4, 32'd0);

        // short glitch is rejected
        rx = 1'b0;
        tick(3);
        rx = 1'b1;
        tick(30);
        rd_chk("glitch_status", 32'd4, 32'd0);
        send_frame(8'h5A, 1'b1);
        tick(5);
        rd_chk("glitch_next", 32'd0, 32'h5A);

        // framing error then a held break
        send_frame(8'h3C, 1'b0);
        tick(20);
        rd_chk("brk_ferr", 32'd4, 32'h4);
        wr(32'd4, 32'h4);
        tick(170);
        rd_chk("brk_once", 32'd4, 32'd0);
        rx = 1'b1;
        tick(20);
        send_frame(8'h7E, 1'b1);
        tick(5);
        rd_chk("brk_rec_st", 32'd4, 32'h101);
        rd_chk("brk_rec_d", 32'd0, 32'h7E);

        // reset in the middle of data bit 4
        send_frame(8'h11, 1'b1);
        tick(5);
        check("pre_rst_irq", {31'd0, rx_irq}, 32'd1);
        rx = 1'b0;
        tick(DC);
        for (int i = 0; i < 5; i++) begin
            rx = ((8'hA5 >> i) & 8'h1) != 8'h0;
            tick(DC);
        end
        rst_n = 1'b0;
        #1;
        check("mid_rst_irq", {31'd0, rx_irq}, 32'd0);
        check("mid_rst_ack", {31'd0, wbb.ACK}, 32'd0);
        check("mid_rst_dat", wbb.DAT_I, 32'd0);
        rx = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(20);
        rd_chk("post_rst_st", 32'd4, 32'd0);
        send_frame(8'hA5, 1'b1);
        tick(5);
        rd_chk("post_rst_st2", 32'd4, 32'h101);
        rd_chk("post_rst_d", 32'd0, 32'hA5);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
